// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the game-round countdown timer: state encoding,
// BCD digit limit and the default one-second tick count.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX               = 4'd9;
  localparam int         TICKS_PER_SEC_DEFAULT = 50000000;

endpackage

// File: rtl/countdown_timer_seg7.sv
// BCD digit to active-low seven-segment pattern (gfedcba); non-BCD codes blank.
module seg7_bcd_decoder (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/countdown_timer.sv
// Four-digit BCD countdown timer: loads a start value, decrements once per
// second, raises game_over at 0000 and drives four seven-segment displays.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEFAULT,
  parameter int DIV_W         = 32
) (
  input  logic        clkin,
  input  logic        reset,
  input  logic        start,
  input  logic        pause,
  input  logic [15:0] load_val,
  output logic        game_over,
  output logic        running,
  output logic [6:0]  hex01,
  output logic [6:0]  hex02,
  output logic [6:0]  hex03,
  output logic [6:0]  hex04
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICKS_PER_SEC - 1);

  function automatic logic [3:0] sat_digit(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

  function automatic logic [15:0] bcd_clamp(input logic [15:0] v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = sat_digit(v[4*i +: 4]);
    return r;
  endfunction

  // Ripple borrow from the ones digit upward; a 0 digit wraps to 9 and passes the borrow on.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        borrow;
    logic [3:0]  d;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = v[4*i +: 4];
      if (borrow) begin
        if (d == 4'd0) begin
          r[4*i +: 4] = BCD_MAX;
        end else begin
          r[4*i +: 4] = d - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  state_t           state;
  logic [15:0]      count;
  logic [DIV_W-1:0] div;

  logic [15:0] load_clamped;
  logic [15:0] count_dec;
  logic        tick;

  assign load_clamped = bcd_clamp(load_val);
  assign count_dec    = bcd_dec(count);
  assign tick         = (div == DIV_LAST);

  always_ff @(posedge clkin) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      div       <= '0;
      game_over <= 1'b0;
      running   <= 1'b0;
    end else if (start) begin
      count <= load_clamped;
      div   <= '0;
      if (load_clamped == 16'h0000) begin
        state     <= DONE;
        game_over <= 1'b1;
        running   <= 1'b0;
      end else begin
        state     <= RUN;
        game_over <= 1'b0;
        running   <= 1'b1;
      end
    end else begin
      case (state)
        RUN: begin
          if (tick) begin
            div   <= '0;
            count <= count_dec;
          end else begin
            div <= div + 1'b1;
          end
          // Reaching zero wins over a simultaneous pause request.
          if (tick && count_dec == 16'h0000) begin
            state     <= DONE;
            game_over <= 1'b1;
            running   <= 1'b0;
          end else if (pause) begin
            state   <= PAUSED;
            running <= 1'b0;
          end
        end
        PAUSED: begin
          if (!pause) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  seg7_bcd_decoder u_dig1 (.bcd(count[3:0]),   .seg(hex01));
  seg7_bcd_decoder u_dig2 (.bcd(count[7:4]),   .seg(hex02));
  seg7_bcd_decoder u_dig3 (.bcd(count[11:8]),  .seg(hex03));
  seg7_bcd_decoder u_dig4 (.bcd(count[15:12]), .seg(hex04));

endmodule

// File: tb/tb_countdown_timer.sv
// Directed and randomized checks of countdown_timer against an integer-valued
// behavioural model of the countdown.
module tb_countdown_timer;

  localparam int T = 4;

  logic        clkin = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic [15:0] load_val = '0;
  logic        game_over, running;
  logic [6:0]  hex01, hex02, hex03, hex04;

  countdown_timer #(.TICKS_PER_SEC(T), .DIV_W(32)) dut (
    .clkin(clkin), .reset(reset), .start(start), .pause(pause),
    .load_val(load_val), .game_over(game_over), .running(running),
    .hex01(hex01), .hex02(hex02), .hex03(hex03), .hex04(hex04)
  );

  always #5 clkin = ~clkin;

  int n_cmp = 0;
  int n_err = 0;

  // Model: the remaining time as a plain integer, divider phase, and activity flags.
  int m_val = 0;
  int m_div = 0;
  bit m_counting = 0;
  bit m_held = 0;
  bit m_finished = 0;

  logic [6:0] SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic int load_value(input logic [15:0] v);
    int r = 0;
    int d;
    for (int k = 3; k >= 0; k--) begin
      d = int'(v[4*k +: 4]);
      if (d > 9) d = 9;
      r = r * 10 + d;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input int v, input int place);
    int d = v;
    for (int k = 0; k < place; k++) d = d / 10;
    return SEG[d % 10];
  endfunction

  task automatic model(input bit r, input bit s, input bit p, input logic [15:0] lv);
    if (r) begin
      m_val = 0; m_div = 0; m_counting = 0; m_held = 0; m_finished = 0;
    end else if (s) begin
      m_val = load_value(lv); m_div = 0; m_held = 0;
      m_finished = (m_val == 0);
      m_counting = !m_finished;
    end else if (m_counting) begin
      if (m_div == T - 1) begin
        m_div = 0;
        m_val = m_val - 1;
      end else begin
        m_div = m_div + 1;
      end
      if (m_val == 0) begin
        m_counting = 0; m_finished = 1;
      end else if (p) begin
        m_counting = 0; m_held = 1;
      end
    end else if (m_held && !p) begin
      m_held = 0; m_counting = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".running"},   16'(running),   16'(m_counting));
    chk({tag, ".game_over"}, 16'(game_over), 16'(m_finished));
    chk({tag, ".hex01"}, 16'(hex01), 16'(seg_of(m_val, 0)));
    chk({tag, ".hex02"}, 16'(hex02), 16'(seg_of(m_val, 1)));
    chk({tag, ".hex03"}, 16'(hex03), 16'(seg_of(m_val, 2)));
    chk({tag, ".hex04"}, 16'(hex04), 16'(seg_of(m_val, 3)));
  endtask

  task automatic step(input string tag, input bit r, input bit s, input bit p,
                      input logic [15:0] lv);
    reset = r; start = s; pause = p; load_val = lv;
    @(posedge clkin);
    model(r, s, p, lv);
    #1;
    check_model(tag);
  endtask

  initial begin
    logic [15:0] lv;
    bit          p;

    // Reset state
    step("reset", 1, 0, 0, 16'h0000);
    chk("reset.hex01_const", 16'(hex01), 16'h0040);
    chk("reset.running_const", 16'(running), 16'h0000);

    // Count 0003 down to DONE: running on the load edge, game_over on the 12th edge
    step("t1.load", 0, 1, 0, 16'h0003);
    chk("t1.running_rise", 16'(running), 16'h0001);
    for (int i = 1; i <= 12; i++) step("t1.count", 0, 0, 0, 16'h0000);
    chk("t1.game_over_edge12", 16'(game_over), 16'h0001);
    chk("t1.running_fall", 16'(running), 16'h0000);
    step("t1.hold", 0, 0, 0, 16'h0000);

    // Full borrow chain 1000 -> 0999
    step("t2.load", 0, 1, 0, 16'h1000);
    for (int i = 0; i < T; i++) step("t2.tick", 0, 0, 0, 16'h0000);
    chk("t2.hex04", 16'(hex04), 16'h0040);
    chk("t2.hex03", 16'(hex03), 16'h0010);
    chk("t2.hex01", 16'(hex01), 16'h0010);

    // Pause mid-period, then resume: decrement lands on the 2nd edge after release
    step("t3.load", 0, 1, 0, 16'h0010);
    step("t3.run", 0, 0, 0, 16'h0000);
    step("t3.run", 0, 0, 0, 16'h0000);
    for (int i = 0; i < 10; i++) step("t3.pause", 0, 0, 1, 16'h0000);
    chk("t3.paused_hex02", 16'(hex02), 16'h0079);
    step("t3.rel1", 0, 0, 0, 16'h0000);
    chk("t3.rel1_hex01", 16'(hex01), 16'h0040);
    step("t3.rel2", 0, 0, 0, 16'h0000);
    chk("t3.rel2_hex01", 16'(hex01), 16'h0010);
    chk("t3.rel2_hex02", 16'(hex02), 16'h0040);

    // start beats pause; clamped load of 00AF is 0099
    step("t4.rst", 1, 0, 0, 16'h0000);
    step("t4.load", 0, 1, 1, 16'h00AF);
    chk("t4.running", 16'(running), 16'h0001);
    chk("t4.hex02", 16'(hex02), 16'h0010);
    step("t4.pause", 0, 0, 1, 16'h0000);
    chk("t4.paused", 16'(running), 16'h0000);

    // Loading 0000 while DONE stays DONE; loading 0005 drops game_over at once
    step("t5.load1", 0, 1, 0, 16'h0001);
    for (int i = 0; i < T; i++) step("t5.run", 0, 0, 0, 16'h0000);
    step("t5.zero", 0, 1, 0, 16'h0000);
    chk("t5.still_done", 16'(game_over), 16'h0001);
    step("t5.reload", 0, 1, 0, 16'h0005);
    chk("t5.go_fall", 16'(game_over), 16'h0000);

    // Reset mid-count with divider at 2
    step("t6.load", 0, 1, 0, 16'h0042);
    step("t6.run", 0, 0, 0, 16'h0000);
    step("t6.run", 0, 0, 0, 16'h0000);
    step("t6.reset", 1, 0, 0, 16'h0000);
    chk("t6.hex04", 16'(hex04), 16'h0040);
    chk("t6.hex01", 16'(hex01), 16'h0040);

    // Randomized traffic
    p = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) lv = 16'($urandom_range(0, 4));
      else lv = 16'($urandom);
      if ($urandom_range(0, 9) == 0) p = ~p;
      step("rand", ($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0), p, lv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
